uart_tx_arbiter: RTL and testbench

Shares the single `UART_CONTROLLER_WRITE` transmitter between two byte-stream requesters. Channel 0 is the image dump stream (SDRAM pixels); channel 1 is the debug/status text stream. Arbitration is frame-atomic: a granted channel keeps the UART until it delivers a byte marked `last`. The block drives the transmitter's `WR`/`write_data` pins with the required setup, strobe and drain sequencing, so requesters never touch `busy`.

---
 rtl/uart_arb_pkg.sv | 31 +++
 rtl/uart_arb_rr.sv | 18 +
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-channel UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        DRAIN  = 3'd3,
        GAP    = 3'd4
    } arb_state_e;

    // Channel indices: image dump stream and debug/status text stream.
    localparam int CH_IMG = 0;
    localparam int CH_DBG = 1;

    localparam int DEF_SETUP_CYCLES = 16;
    localparam int DEF_BUSY_TIMEOUT = 1023;
    localparam int CNT_W            = 16;

    // One byte as offered by a requester and held for the transmitter.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_byte_t;

    // State counters stop at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// Two-way round-robin picker: the lone requester wins, a tie goes to the
// channel that was not served last.
module uart_arb_rr
    import uart_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_served,   // 1 = debug channel was served last
    output logic [1:0] pick
);

    // One-hot pick, purely combinational.
    always_comb begin
        pick         = 2'b00;
        pick[CH_IMG] = valid[CH_IMG] & (~valid[CH_DBG] | last_served);
        pick[CH_DBG] = valid[CH_DBG] & (~valid[CH_IMG] | ~last_served);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic arbiter sharing one UART transmitter between the image dump
// stream and the debug text stream, with setup/strobe/drain sequencing of WR.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ch0_valid,
    input  logic [7:0] ch0_data,
    input  logic       ch0_last,
    output logic       ch0_ready,
    input  logic       ch1_valid,
    input  logic [7:0] ch1_data,
    input  logic       ch1_last,
    output logic       ch1_ready,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    tx_byte_t         cap_q, cap_d;
    tx_byte_t         ch0_byte, ch1_byte, owner_byte;
    logic [1:0]       grant_d, pick;
    logic             ready0_d, ready1_d, err_d;
    logic             last_srv_q, last_srv_d;
    logic             owner_valid;

    assign ch0_byte    = {ch0_last, ch0_data};
    assign ch1_byte    = {ch1_last, ch1_data};
    assign owner_valid = grant[CH_DBG] ? ch1_valid : ch0_valid;
    assign owner_byte  = grant[CH_DBG] ? ch1_byte  : ch0_byte;
    assign tx_data     = cap_q.data;

    uart_arb_rr u_rr (
        .valid       ({ch1_valid, ch0_valid}),
        .last_served (last_srv_q),
        .pick        (pick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, capture, grant and handshake decisions.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        grant_d    = grant;
        last_srv_d = last_srv_q;
        ready0_d   = 1'b0;
        ready1_d   = 1'b0;
        err_d      = timeout_err;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    grant_d  = pick;
                    ready0_d = pick[CH_IMG];
                    ready1_d = pick[CH_DBG];
                    cap_d    = pick[CH_DBG] ? ch1_byte : ch0_byte;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q >= SETUP_LAST) state_d = STROBE;
            end
            STROBE: begin
                if (tx_busy) begin
                    state_d = DRAIN;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Busy stuck high here is waited out indefinitely.
                if (!tx_busy) begin
                    if (cap_q.last) begin
                        grant_d    = 2'b00;
                        last_srv_d = grant[CH_DBG];
                        state_d    = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Only the owner may continue its frame.
                if (owner_valid) begin
                    ready0_d = grant[CH_IMG];
                    ready1_d = grant[CH_DBG];
                    cap_d    = owner_byte;
                    state_d  = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cap_q       <= '0;
            grant       <= 2'b00;
            ch0_ready   <= 1'b0;
            ch1_ready   <= 1'b0;
            tx_wr       <= 1'b0;
            timeout_err <= 1'b0;
            last_srv_q  <= 1'(CH_DBG);
        end else begin
            cnt_q       <= (state_d != state_q) ? '0 : sat_inc(cnt_q);
            cap_q       <= cap_d;
            grant       <= grant_d;
            ch0_ready   <= ready0_d;
            ch1_ready   <= ready1_d;
            tx_wr       <= (state_d == STROBE);
            timeout_err <= err_d;
            last_srv_q  <= last_srv_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int SETUP = 16;
    localparam int TMO   = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ch0_valid = 1'b0, ch0_last = 1'b0, ch1_valid = 1'b0, ch1_last = 1'b0;
    logic [7:0] ch0_data = 8'h00, ch1_data = 8'h00;
    logic       ch0_ready, ch1_ready, tx_wr, timeout_err;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic [1:0] grant;

    int n_tests = 0, n_fail = 0;

    uart_tx_arbiter #(.SETUP_CYCLES(SETUP), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_last(ch0_last), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_last(ch1_last), .ch1_ready(ch1_ready),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART model: accepts a strobe when idle, then stays busy busy_len cycles.
    int       busy_len = 100;
    bit       uart_dead = 1'b0;
    int       bcnt = 0;
    always @(posedge clk) begin
        if (uart_dead) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end else if (tx_wr) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end
    end

    // Inputs as the DUT saw them at the last rising edge.
    logic [1:0] in_v;
    logic [7:0] in_d0, in_d1;
    logic       in_l0, in_l1;
    always @(posedge clk) begin
        in_v  <= {ch1_valid, ch0_valid};
        in_d0 <= ch0_data;  in_l0 <= ch0_last;
        in_d1 <= ch1_data;  in_l1 <= ch1_last;
    end

    // Reference model: frames are atomic, ties alternate, each accepted byte
    // appears on the UART in order, SETUP cycles after its acceptance.
    logic [8:0] acc_q[$];
    logic [7:0] tx_log[$];
    int         served_q[$];
    bit         m_owned = 1'b0, m_last = 1'b1, wr_prev = 1'b0;
    int         m_own = 0, c = 0, cyc = 0, rdy_cyc = 0;
    int         rdy_cnt0 = 0, rdy_cnt1 = 0, tx_cnt = 0, sent_cnt = 0;
    logic [8:0] cur = '0;
    logic [1:0] rdy;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_owned = 1'b0; m_last = 1'b1; wr_prev = 1'b0;
            acc_q.delete();
        end else begin
            rdy = {ch1_ready, ch0_ready};
            if (rdy != 2'b00) begin
                chk("ready_onehot", $countones(rdy), 1);
                c = rdy[1] ? 1 : 0;
                if (c == 1) rdy_cnt1++; else rdy_cnt0++;
                if (!m_owned) begin
                    if (in_v == 2'b11) chk("tie_winner", c, m_last ? 0 : 1);
                    m_owned = 1'b1; m_own = c;
                    served_q.push_back(c);
                end else begin
                    chk("frame_owner", c, m_own);
                end
                chk("ready_had_valid", in_v[c], 1);
                chk("grant_onehot", grant, (c == 1) ? 2 : 1);
                acc_q.push_back(c ? {in_l1, in_d1} : {in_l0, in_d0});
                rdy_cyc = cyc;
            end
            if (tx_wr && !wr_prev) begin
                chk("wr_has_byte", acc_q.size() != 0, 1);
                if (acc_q.size() != 0) begin
                    cur = acc_q.pop_front();
                    chk("tx_data", tx_data, cur[7:0]);
                    chk("setup_delay", cyc - rdy_cyc, SETUP);
                    tx_log.push_back(tx_data);
                    tx_cnt++;
                    if (cur[8]) begin m_owned = 1'b0; m_last = (m_own == 1); end
                end
            end
            if (!tx_wr && wr_prev) chk("tx_data_hold", tx_data, cur[7:0]);
            wr_prev = tx_wr;
        end
    end

    task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
        if (ch == 0) begin ch0_valid = v; ch0_data = d; ch0_last = l; end
        else         begin ch1_valid = v; ch1_data = d; ch1_last = l; end
    endtask

    // Offer one frame of n bytes; optional valid drops and a forced gap.
    task automatic send_frame(input int ch, input int n, input int drop_pct,
                              input int gap_at, input int gap_len, input logic [31:0] fix);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic       l;
            bit         got;
            logic       seen;
            int         waited;
            b = (fix != 0) ? fix[8*i +: 8] : 8'($urandom);
            l = (i == n - 1);
            got = 1'b0; seen = 1'b0; waited = 0;
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            drive(ch, 1'b1, b, l);
            while (!got) begin
                @(negedge clk);
                seen = (ch == 0) ? ch0_ready : ch1_ready;
                waited++;
                if (seen) begin
                    got = 1'b1; sent_cnt++;
                end else if (waited > 20000) begin
                    chk("ready_wait", seen, 1'b1);
                    got = 1'b1;
                end else if ($urandom_range(99) < drop_pct) begin
                    drive(ch, 1'b0, b, l);
                    repeat ($urandom_range(4, 1)) @(negedge clk);
                    drive(ch, 1'b1, b, l);
                end
            end
            drive(ch, 1'b0, b, l);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((grant != 2'b00 || tx_busy || tx_wr) && n < 5000) begin
            @(negedge clk); n++;
        end
        chk(tag, grant, 2'b00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic t_basic();
        int b0 = rdy_cnt0;
        busy_len = 100;
        tx_log.delete();
        send_frame(0, 2, 0, -1, 0, 32'h0000_6D69);
        wait_idle("basic_release");
        chk("basic_ready_cnt", rdy_cnt0 - b0, 2);
        chk("basic_nbytes", tx_log.size(), 2);
        chk("basic_byte0", tx_log[0], 8'h69);
        chk("basic_byte1", tx_log[1], 8'h6D);
    endtask

    task automatic t_tie(input string tag);
        busy_len = 20;
        served_q.delete();
        fork
            send_frame(0, 1, 0, -1, 0, 0);
            send_frame(1, 1, 0, -1, 0, 0);
        join
        wait_idle({tag, "_release"});
        chk({tag, "_count"}, served_q.size(), 2);
        chk({tag, "_first"}, served_q[0], 0);
        chk({tag, "_second"}, served_q[1], 1);
    endtask

    task automatic t_gap();
        int b0 = rdy_cnt0;
        int b1 = rdy_cnt1;
        busy_len = 10;
        served_q.delete();
        fork
            send_frame(0, 3, 0, 1, 50, 0);
            send_frame(1, 1, 0, -1, 0, 0);
            begin
                int n = 0;
                while (rdy_cnt0 == b0 && n < 500) begin @(negedge clk); n++; end
                repeat (45) @(negedge clk);
                chk("gap_grant", grant, 2'b01);
                chk("gap_no_ch1", rdy_cnt1, b1);
            end
        join
        wait_idle("gap_release");
        chk("gap_order_n", served_q.size(), 2);
        chk("gap_order_1", served_q[1], 1);
    endtask

    task automatic t_timeout();
        uart_dead = 1'b1;
        fork
            send_frame(0, 1, 0, -1, 0, 0);
            begin
                int n = 0;
                while (!tx_wr && n < 200) begin @(negedge clk); n++; end
                chk("tmo_strobe", tx_wr, 1'b1);
                repeat (TMO - 1) @(negedge clk);
                chk("tmo_held", tx_wr, 1'b1);
                chk("tmo_err_early", timeout_err, 1'b0);
                @(negedge clk);
                chk("tmo_wr_drop", tx_wr, 1'b0);
                chk("tmo_err", timeout_err, 1'b1);
            end
        join
        wait_idle("tmo_release");
        uart_dead = 1'b0;
        busy_len = 15;
        send_frame(0, 2, 0, -1, 0, 0);
        wait_idle("tmo_next_release");
        chk("tmo_sticky", timeout_err, 1'b1);
    endtask

    task automatic t_reset_mid();
        int n = 0;
        busy_len = 20;
        send_frame(0, 1, 0, -1, 0, 0);
        while (!tx_wr && n < 200) begin @(negedge clk); n++; end
        chk("rst_in_strobe", tx_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_wr", tx_wr, 1'b0);
        chk("rst_grant", grant, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_err_clr", timeout_err, 1'b0);
        t_tie("rst_tie");
    endtask

    task automatic t_alternate();
        send_frame(0, 1, 0, -1, 0, 0);
        wait_idle("alt_pre");
        served_q.delete();
        fork
            repeat (3) send_frame(1, 1, 0, -1, 0, 0);
            repeat (2) send_frame(0, 1, 0, -1, 0, 0);
        join
        wait_idle("alt_release");
        chk("alt_count", served_q.size(), 5);
        for (int i = 0; i < served_q.size(); i++)
            chk("alt_order", served_q[i], (i % 2 == 0) ? 1 : 0);
    endtask

    task automatic t_random();
        for (int r = 0; r < 6; r++) begin
            busy_len = $urandom_range(40, 3);
            fork
                begin
                    int nf = $urandom_range(4, 1);
                    for (int f = 0; f < nf; f++)
                        send_frame(0, $urandom_range(4, 1), 20, -1, 0, 0);
                end
                begin
                    int nf = $urandom_range(4, 1);
                    for (int f = 0; f < nf; f++)
                        send_frame(1, $urandom_range(4, 1), 20, -1, 0, 0);
                end
            join
            wait_idle("rand_release");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hold_wr", tx_wr, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx_wr", tx_wr, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_grant", grant, 2'b00);
        chk("reset_ready", {ch1_ready, ch0_ready}, 2'b00);
        chk("reset_err", timeout_err, 1'b0);

        t_basic();
        do_reset();
        t_tie("tie");
        t_gap();
        t_timeout();
        t_reset_mid();
        t_alternate();
        t_random();

        chk("bytes_conserved", tx_cnt, sent_cnt);
        chk("model_drained", acc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
